top_level: RTL and testbench

//  Program-1 engine: LFSR-encrypts a 64-byte space-padded message held in on-chip data memory.

---
 rtl/top_level_pkg.sv | 39 +++
 rtl/data_mem.sv | 35 +++
 rtl/top_level.sv | 128 ++++++++++++
 tb/tb_top_level.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// Shared constants for the LFSR message encryptor: memory map, tap table, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   address constants for the message/config/output regions of data memory
//   7-bit LFSR tap table indexed by pt_no, plus the pt_no -> index lookup
//   FSM state encoding
package top_level_pkg;

  localparam int MSG_BASE  = 0;
  localparam int MSG_LAST  = 60;   // last message byte; offsets beyond it read as padding
  localparam int PRE_ADDR  = 61;
  localparam int PT_ADDR   = 62;
  localparam int SEED_ADDR = 63;
  localparam int OUT_BASE  = 64;

  // The LFSR is 7 bits wide and every tap value fits in 7 bits, so the table is stored narrow.
  localparam logic [6:0] TAP_TABLE [0:8] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_PRE,
    S_LD_TAP,
    S_LD_SEED,
    S_RUN,
    S_DONE
  } state_t;

  // pt_no 8 is the only value reaching the ninth entry; everything else folds onto 0..7.
  function automatic logic [6:0] tap_lookup(input logic [3:0] pt_lo);
    logic [3:0] idx;
    idx = (pt_lo == 4'd8) ? 4'd8 : {1'b0, pt_lo[2:0]};
    return TAP_TABLE[idx];
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256-word data memory: combinational read port, synchronous write port.
// Latency: read is same-cycle, write lands on the rising edge.
// Backpressure: none; a write is accepted every cycle we_i is high.
//
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
// Core is left as a plain array so it can be preloaded and inspected hierarchically.
module data_mem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] Core [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      Core[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = Core[raddr_i];

endmodule

// File: rtl/top_level.sv
// LFSR-encrypts a 64-byte space-padded message from DM[0:63] into DM[64:127].
// Latency: Ack rises on the 68th rising edge after Start is sampled low (3 loads + 64 bytes + 1).
// Backpressure: none; Start high holds the engine in IDLE, Reset aborts at once.
//
// Ports:
//   Clk    clock, all state on rising edge
//   Reset  synchronous active-high reset, priority over Start
//   Start  high = hold in IDLE, low = run
//   Ack    high once all 64 output bytes are written
// Build option: define TRACE_EN to print one simulation trace line per RUN cycle.
module top_level
  import top_level_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int MSG_LEN = 64
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  localparam logic [DW-2:0] SPACE = (DW-1)'('h20);

  state_t        state_q;
  logic [AW-1:0] i_q;
  logic [DW-1:0] pre_q;
  logic [DW-2:0] taps_q;
  logic [DW-2:0] lfsr_q, lfsr_d;
  logic          ack_q;

  logic [AW-1:0] raddr, waddr, off;
  logic [DW-1:0] rdata, wdata;
  logic [DW-2:0] src, x;
  logic          pad, we;

  data_mem #(.DW(DW), .AW(AW)) DM1 (
    .clk_i   (Clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    off = i_q - AW'(pre_q);
    // Leading pre_length slots and anything past the message end are spaces.
    pad = (i_q < AW'(pre_q)) || (off > AW'(MSG_LAST));

    raddr = AW'(MSG_BASE);
    case (state_q)
      S_LD_PRE:  raddr = AW'(PRE_ADDR);
      S_LD_TAP:  raddr = AW'(PT_ADDR);
      S_LD_SEED: raddr = AW'(SEED_ADDR);
      S_RUN:     raddr = pad ? AW'(MSG_BASE) : off;
      default:   raddr = AW'(MSG_BASE);
    endcase

    // Bit 7 of the source byte is discarded; it is replaced by the parity of the low 7 bits.
    src    = pad ? SPACE : rdata[DW-2:0];
    x      = src ^ lfsr_q;
    wdata  = {^x, x};
    waddr  = AW'(OUT_BASE) + i_q;
    // Gate with Reset so an aborting edge never writes the current byte.
    we     = (state_q == S_RUN) && !Reset;
    lfsr_d = {lfsr_q[DW-3:0], ^(lfsr_q & taps_q)};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      i_q     <= '0;
      lfsr_q  <= '0;
      pre_q   <= '0;
      taps_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          i_q   <= '0;
          if (!Start) state_q <= S_LD_PRE;
        end
        S_LD_PRE: begin
          pre_q   <= rdata;
          state_q <= S_LD_TAP;
        end
        S_LD_TAP: begin
          taps_q  <= tap_lookup(rdata[3:0]);
          state_q <= S_LD_SEED;
        end
        S_LD_SEED: begin
          lfsr_q  <= rdata[DW-2:0];
          state_q <= S_RUN;
        end
        S_RUN: begin
          lfsr_q <= lfsr_d;
          if (i_q == AW'(MSG_LEN-1)) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        S_DONE: begin
          if (Start) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ack = ack_q;

`ifdef TRACE_EN
  always @(posedge Clk) begin
    if (!Reset && state_q == S_RUN)
      $display("[TRACE] i=%0d src=%02h lfsr=%02h out=%02h", i_q, {1'b0, src}, {1'b0, lfsr_q}, wdata);
  end
`else
`endif

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table of run configurations plus reset corner cases.
// Expected output bytes come from a bench-side golden model and are queued per run.
module tb_top_level;
  import top_level_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b1;
  logic Ack;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tb_mem [0:63];
  logic [6:0] tb_taps [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  string watson = "Mr. Watson, come here. I want to see you.";

  typedef struct {
    logic [7:0] pt;
    logic [7:0] seed;
    logic [7:0] pre;
    int         msg;       // 0 = all spaces, 1 = Watson text
    bit         has_exp;
    logic [7:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [0:12];

  top_level dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sentinel(input int k);
    logic [7:0] kb;
    kb = k[7:0];
    return kb ^ 8'hC3;
  endfunction

  // Preload DUT memory and the bench's own copy of the input region.
  task automatic load(input logic [7:0] pt, input logic [7:0] seed, input logic [7:0] pre, input int msg);
    for (int k = 0; k < 64; k++) begin
      logic [7:0] b;
      if (k <= 60) b = (msg == 1 && k < watson.len()) ? watson[k] : 8'h20;
      else if (k == 61) b = pre;
      else if (k == 62) b = pt;
      else b = seed;
      tb_mem[k] = b;
      dut.DM1.Core[k] = b;
    end
    for (int k = 64; k < 128; k++) dut.DM1.Core[k] = sentinel(k);
  endtask

  // Golden model: push the 64 expected output bytes for the current tb_mem.
  task automatic push_expected();
    logic [6:0] lfsr, taps, x;
    logic [7:0] src, pre, pt;
    int idx;
    pre  = tb_mem[61];
    pt   = tb_mem[62];
    idx  = (pt[3:0] == 4'd8) ? 8 : int'(pt[2:0]);
    taps = tb_taps[idx];
    lfsr = tb_mem[63][6:0];
    for (int i = 0; i < 64; i++) begin
      if (i < int'(pre) || i - int'(pre) > 60) src = 8'h20;
      else src = tb_mem[i - int'(pre)];
      x = src[6:0] ^ lfsr;
      exp_q.push_back({^x, x});
      lfsr = {lfsr[5:0], ^(lfsr & taps)};
    end
  endtask

  // Drop Start, count edges until Ack, then compare the output region against the queue.
  task automatic run_and_check(input string tag);
    int n;
    logic [7:0] e;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge Clk); #1;
      n++;
      if (Ack) break;
    end
    chk({tag, "_ack_latency"}, n, 68);
    for (int k = 0; k < 64; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, k), dut.DM1.Core[64+k], e);
    end
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_ack_clear"}, Ack, 0);
  endtask

  initial begin
    // Directed configurations with hand-computed first bytes.
    vecs[0] = '{8'd3, 8'h01, 8'd10, 0, 1'b1, 8'h21, 8'h22, 8'hA5};
    vecs[1] = '{8'd0, 8'h7F, 8'd10, 0, 1'b1, 8'h5F, 8'hDE, 8'h5C};
    // Watson text over every table entry, plus pt_no=12 aliasing to index 4 and a zero seed.
    for (int p = 0; p <= 8; p++)
      vecs[2+p] = '{p[7:0], 8'($urandom_range(1, 127)), 8'($urandom_range(10, 15)), 1, 1'b0, 8'h0, 8'h0, 8'h0};
    vecs[11] = '{8'd12, 8'($urandom_range(1, 127)), 8'($urandom_range(10, 15)), 1, 1'b0, 8'h0, 8'h0, 8'h0};
    vecs[12] = '{8'd5, 8'h00, 8'd12, 1, 1'b1, 8'hA0, 8'hA0, 8'hA0};

    // Reset wins over Start low.
    Reset = 1'b1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ack", Ack, 0);
    chk("reset_state", dut.state_q, S_IDLE);
    chk("reset_i", dut.i_q, 0);
    chk("reset_lfsr", dut.lfsr_q, 0);

    // Start held high: stays idle, output region untouched.
    load(8'd3, 8'h01, 8'd10, 0);
    @(negedge Clk);
    Start = 1'b1;
    Reset = 1'b0;
    repeat (30) @(posedge Clk);
    #1;
    chk("hold_ack", Ack, 0);
    chk("hold_state", dut.state_q, S_IDLE);
    for (int k = 64; k < 128; k++) chk($sformatf("hold_untouched%0d", k), dut.DM1.Core[k], sentinel(k));

    // Table-driven runs.
    for (int v = 0; v < 13; v++) begin
      load(vecs[v].pt, vecs[v].seed, vecs[v].pre, vecs[v].msg);
      push_expected();
      run_and_check($sformatf("vec%0d", v));
      if (vecs[v].has_exp) begin
        chk($sformatf("vec%0d_const0", v), dut.DM1.Core[64], vecs[v].e0);
        chk($sformatf("vec%0d_const1", v), dut.DM1.Core[65], vecs[v].e1);
        chk($sformatf("vec%0d_const2", v), dut.DM1.Core[66], vecs[v].e2);
      end
    end

    // Reset during RUN i=20: bytes 0..19 written, the rest untouched, then a clean rerun.
    load(8'd6, 8'h35, 8'd11, 1);
    push_expected();
    @(negedge Clk);
    Start = 1'b0;
    repeat (24) @(posedge Clk);
    @(negedge Clk);
    chk("abort_at_i20", dut.i_q, 20);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk); #1;
    chk("abort_state", dut.state_q, S_IDLE);
    chk("abort_ack", Ack, 0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (k < 20) chk($sformatf("abort_written%0d", k), dut.DM1.Core[64+k], e);
      else chk($sformatf("abort_untouched%0d", k), dut.DM1.Core[64+k], sentinel(64+k));
    end
    push_expected();
    run_and_check("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
